// File: rtl/fwd_hazard_unit_pkg.sv
// ============================================================================
// fwd_pkg : shared types and helpers for the forwarding / hazard unit
// Rev 1.0
// ============================================================================
`default_nettype none

package fwd_pkg;

    // Tag storage width; the unit supports REG_ADDR_W up to this value.
    localparam int DST_W    = 8;
    localparam int SEL_RF   = 0;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             load;
        logic [DST_W-1:0] dst;
    } fwd_entry_t;

    function automatic logic entry_hits(input fwd_entry_t e, input logic [DST_W-1:0] src);
        return e.valid && e.wr && (e.dst == src) && (src != DST_W'(REG_ZERO));
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_unit_if.sv
// ============================================================================
// fwd_hazard_unit_if : decode-side bus of the forwarding / hazard unit
// Optional macro FWD_STATS_EN adds the stall statistics counters. Rev 1.0
// ============================================================================
`default_nettype none

interface fwd_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic                  id_store;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_load;
    logic                  id_branch;
    logic                  flush;
    logic [SEL_W-1:0]      exe_a_sel;
    logic [SEL_W-1:0]      exe_b_sel;
    logic [SEL_W-1:0]      mem_data_sel;
    logic                  stall;
`ifdef FWD_STATS_EN
    logic [31:0]           stat_load_stalls;
    logic [31:0]           stat_branch_stalls;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_store,
               id_rd, id_reg_write, id_load, id_branch, flush,
        input  exe_a_sel, exe_b_sel, mem_data_sel, stall,
               stat_load_stalls, stat_branch_stalls
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_store,
               id_rd, id_reg_write, id_load, id_branch, flush,
        output exe_a_sel, exe_b_sel, mem_data_sel, stall,
               stat_load_stalls, stat_branch_stalls
    );
`else
    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_store,
               id_rd, id_reg_write, id_load, id_branch, flush,
        input  exe_a_sel, exe_b_sel, mem_data_sel, stall
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_store,
               id_rd, id_reg_write, id_load, id_branch, flush,
        output exe_a_sel, exe_b_sel, mem_data_sel, stall
    );
`endif
endinterface

`default_nettype wire

// File: rtl/fwd_hazard_unit_match.sv
// ============================================================================
// fwd_match : priority matcher of one source operand against the tag pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_match
    import fwd_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  wire logic [DST_W-1:0]             src,
    input  wire logic                         used,
    input  wire fwd_entry_t [NUM_STAGES:1]    entries,
    output logic [SEL_W-1:0]                  sel,
    output logic                              hit1,
    output logic                              hit2_load
);

    always_comb begin
        sel = SEL_W'(SEL_RF);
        // Scan oldest to youngest so the youngest writer overwrites the select.
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (used && entry_hits(entries[k], src)) begin
                sel = SEL_W'(k);
            end
        end
        hit1      = used && entry_hits(entries[1], src);
        hit2_load = used && entry_hits(entries[2], src) && entries[2].load;
    end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// fwd_hazard_unit : operand forwarding selects and load-use / branch stalls
// Optional macro FWD_STATS_EN adds saturating stall counters. Rev 1.0
// ============================================================================
`default_nettype none

module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  wire logic         CLK,
    input  wire logic         RESET,
    fwd_hazard_unit_if.slave  bus
);

    fwd_entry_t [NUM_STAGES:1] r_entries;
    fwd_entry_t                w_id_entry;
    logic [SEL_W-1:0]          w_a_sel, w_b_sel, w_s_sel;
    logic                      w_a_hit1, w_b_hit1, w_s_hit1;
    logic                      w_a_hit2_load, w_b_hit2_load, w_s_hit2_load;
    logic                      w_load_use, w_branch_haz, w_stall;

    fwd_match #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_match_a (
        .src(DST_W'(bus.id_rs)), .used(bus.id_rs_used), .entries(r_entries),
        .sel(w_a_sel), .hit1(w_a_hit1), .hit2_load(w_a_hit2_load)
    );

    fwd_match #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_match_b (
        .src(DST_W'(bus.id_rt)), .used(bus.id_rt_used), .entries(r_entries),
        .sel(w_b_sel), .hit1(w_b_hit1), .hit2_load(w_b_hit2_load)
    );

    // Store data is consumed in MEM, so a load one ahead is reachable by WB->MEM forwarding.
    fwd_match #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_match_s (
        .src(DST_W'(bus.id_rt)), .used(bus.id_store), .entries(r_entries),
        .sel(w_s_sel), .hit1(w_s_hit1), .hit2_load(w_s_hit2_load)
    );

    always_comb begin
        w_load_use   = r_entries[1].load && (w_a_hit1 || w_b_hit1);
        w_branch_haz = bus.id_branch &&
                       (w_a_hit1 || w_b_hit1 || w_a_hit2_load || w_b_hit2_load);
        w_stall      = bus.id_valid && !bus.flush && (w_load_use || w_branch_haz);
        w_id_entry   = '{valid: bus.id_valid, wr: bus.id_reg_write,
                         load: bus.id_load, dst: DST_W'(bus.id_rd)};
    end

    assign bus.exe_a_sel    = w_a_sel;
    assign bus.exe_b_sel    = w_b_sel;
    assign bus.mem_data_sel = w_s_sel;
    assign bus.stall        = w_stall;

    // Older entries always advance; only the slot fed from ID takes a bubble.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_entries <= '0;
        end else begin
            r_entries[NUM_STAGES:2] <= r_entries[NUM_STAGES-1:1];
            r_entries[1]            <= (w_stall || bus.flush) ? '0 : w_id_entry;
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] r_load_stalls;
    logic [31:0] r_branch_stalls;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_load_stalls   <= '0;
            r_branch_stalls <= '0;
        end else if (w_stall) begin
            if (w_load_use) begin
                if (r_load_stalls != '1) r_load_stalls <= r_load_stalls + 32'd1;
            end else if (r_branch_stalls != '1) begin
                r_branch_stalls <= r_branch_stalls + 32'd1;
            end
        end
    end

    assign bus.stat_load_stalls   = r_load_stalls;
    assign bus.stat_branch_stalls = r_branch_stalls;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
// tb_fwd_hazard_unit : directed table, reset corner cases and random stimulus
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

    localparam int NS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_ADDR_W(5), .NUM_STAGES(NS)) if0 ();

    fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_STAGES(NS)) dut (
        .CLK(clk), .RESET(rst), .bus(if0)
    );

    typedef struct {
        bit v; int rs; int rt; bit rsu; bit rtu; bit st;
        int rd; bit wr; bit ld; bit br; bit fl;
    } in_t;
    typedef struct { in_t i; int ea; int eb; int em; bit es; } vec_t;
    typedef struct { bit valid; bit wr; bit load; int dst; } ment_t;

    ment_t mdl [1:NS];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    exp_ld_stalls = 0;
    int    exp_br_stalls = 0;
    vec_t  tbl [24];

    function automatic in_t mk(bit v, int rs, int rt, bit rsu, bit rtu, bit st,
                               int rd, bit wr, bit ld, bit br);
        in_t x;
        x.v = v; x.rs = rs; x.rt = rt; x.rsu = rsu; x.rtu = rtu; x.st = st;
        x.rd = rd; x.wr = wr; x.ld = ld; x.br = br; x.fl = 1'b0;
        return x;
    endfunction
    function automatic in_t alu(int rd, int rs, int rt); return mk(1, rs, rt, 1, 1, 0, rd, 1, 0, 0); endfunction
    function automatic in_t lw(int rd, int rs);          return mk(1, rs, 0, 1, 0, 0, rd, 1, 1, 0); endfunction
    function automatic in_t sw(int rt, int rs);          return mk(1, rs, rt, 1, 0, 1, 0, 0, 0, 0); endfunction
    function automatic in_t beq(int rs, int rt);         return mk(1, rs, rt, 1, 1, 0, 0, 0, 0, 1); endfunction
    function automatic in_t nop();                       return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction

    function automatic vec_t row(in_t x, int a, int b, int m, bit s);
        vec_t r;
        r.i = x; r.ea = a; r.eb = b; r.em = m; r.es = s;
        return r;
    endfunction

    // Reference: the youngest in-flight writer of a nonzero register supplies the value.
    function automatic int msel(int src, bit used);
        if (!used || src == 0) return 0;
        for (int k = 1; k <= NS; k++)
            if (mdl[k].valid && mdl[k].wr && mdl[k].dst == src) return k;
        return 0;
    endfunction

    function automatic bit mload_use(in_t x);
        return mdl[1].load && (msel(x.rs, x.rsu) == 1 || msel(x.rt, x.rtu) == 1);
    endfunction

    function automatic bit mstall(in_t x);
        int sa, sb;
        bit bs;
        sa = msel(x.rs, x.rsu);
        sb = msel(x.rt, x.rtu);
        bs = x.br && (sa == 1 || sb == 1 || (mdl[2].load && (sa == 2 || sb == 2)));
        return x.v && !x.fl && (mload_use(x) || bs);
    endfunction

    function automatic void mclear();
        for (int k = 1; k <= NS; k++) mdl[k] = '{0, 0, 0, 0};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t x);
        if0.id_valid     = x.v;
        if0.id_rs        = 5'(x.rs);
        if0.id_rt        = 5'(x.rt);
        if0.id_rs_used   = x.rsu;
        if0.id_rt_used   = x.rtu;
        if0.id_store     = x.st;
        if0.id_rd        = 5'(x.rd);
        if0.id_reg_write = x.wr;
        if0.id_load      = x.ld;
        if0.id_branch    = x.br;
        if0.flush        = x.fl;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " a_sel"}, int'(if0.exe_a_sel), 0);
        chk({tag, " b_sel"}, int'(if0.exe_b_sel), 0);
        chk({tag, " m_sel"}, int'(if0.mem_data_sel), 0);
        chk({tag, " stall"}, int'(if0.stall), 0);
    endtask

    // One ID cycle: drive, sample at negedge, then advance the model on the edge.
    task automatic run_cycle(input in_t x, input bit use_tbl, input vec_t v, input string tag);
        bit es, lu;
        drive(x);
        @(negedge clk);
        es = mstall(x);
        lu = mload_use(x);
        if (use_tbl) begin
            chk({tag, " a_sel"}, int'(if0.exe_a_sel), v.ea);
            chk({tag, " b_sel"}, int'(if0.exe_b_sel), v.eb);
            chk({tag, " m_sel"}, int'(if0.mem_data_sel), v.em);
            chk({tag, " stall"}, int'(if0.stall), int'(v.es));
        end else begin
            chk({tag, " a_sel"}, int'(if0.exe_a_sel), msel(x.rs, x.rsu));
            chk({tag, " b_sel"}, int'(if0.exe_b_sel), msel(x.rt, x.rtu));
            chk({tag, " m_sel"}, int'(if0.mem_data_sel), msel(x.rt, x.st));
            chk({tag, " stall"}, int'(if0.stall), int'(es));
        end
        @(posedge clk);
        for (int k = NS; k >= 2; k--) mdl[k] = mdl[k-1];
        if (es || x.fl) mdl[1] = '{0, 0, 0, 0};
        else            mdl[1] = '{x.v, x.wr, x.ld, x.rd};
        if (es) begin
            if (lu) exp_ld_stalls++;
            else    exp_br_stalls++;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_t  x;
        vec_t dummy;
        dummy = row(nop(), 0, 0, 0, 0);
        mclear();

        tbl[0]  = row(alu(3, 1, 2),   0, 0, 0, 0);
        tbl[1]  = row(alu(4, 3, 3),   1, 1, 0, 0);
        tbl[2]  = row(alu(9, 1, 2),   0, 0, 0, 0);
        tbl[3]  = row(lw(5, 1),       0, 0, 0, 0);
        tbl[4]  = row(alu(6, 5, 1),   1, 0, 0, 1);
        tbl[5]  = row(alu(6, 5, 1),   2, 0, 0, 0);
        tbl[6]  = row(lw(7, 2),       0, 0, 0, 0);
        tbl[7]  = row(sw(7, 2),       0, 0, 1, 0);
        tbl[8]  = row(alu(0, 1, 5),   0, 0, 0, 0);
        tbl[9]  = row(alu(10, 0, 0),  0, 0, 0, 0);
        tbl[10] = row(alu(4, 1, 2),   0, 0, 0, 0);
        tbl[11] = row(beq(4, 0),      1, 0, 0, 1);
        tbl[12] = row(beq(4, 0),      2, 0, 0, 0);
        tbl[13] = row(lw(4, 1),       0, 0, 0, 0);
        tbl[14] = row(beq(4, 0),      1, 0, 0, 1);
        tbl[15] = row(beq(4, 0),      2, 0, 0, 1);
        tbl[16] = row(beq(4, 0),      3, 0, 0, 0);
        tbl[17] = row(alu(8, 1, 2),   0, 0, 0, 0);
        tbl[18] = row(alu(11, 1, 2),  0, 0, 0, 0);
        tbl[19] = row(alu(8, 1, 2),   0, 0, 0, 0);
        tbl[20] = row(alu(12, 8, 8),  1, 1, 0, 0);
        tbl[21] = row(lw(13, 1),      0, 0, 0, 0);
        x = alu(14, 13, 1);
        x.fl = 1'b1;
        tbl[22] = row(x,              1, 0, 0, 0);
        tbl[23] = row(alu(14, 13, 1), 2, 0, 0, 0);

        // Reset held with a would-be hazard on the ID inputs.
        drive(alu(6, 5, 5));
        @(posedge clk);
        @(negedge clk);
        check_zero("in_reset");
        drive(nop());
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++)
            run_cycle(tbl[i].i, 1'b1, tbl[i], $sformatf("row%0d", i));

`ifdef FWD_STATS_EN
        chk("stat_load_after_table", int'(if0.stat_load_stalls), exp_ld_stalls);
        chk("stat_branch_after_table", int'(if0.stat_branch_stalls), exp_br_stalls);
`endif

        // Asynchronous reset between edges while a load-use stall is showing.
        run_cycle(lw(5, 1), 1'b0, dummy, "pre_rst_lw");
        drive(alu(6, 5, 1));
        @(negedge clk);
        chk("pre_rst stall", int'(if0.stall), 1);
        #1 rst = 1'b1;
        #1;
        check_zero("async_rst");
`ifdef FWD_STATS_EN
        chk("stat_load_rst", int'(if0.stat_load_stalls), 0);
        chk("stat_branch_rst", int'(if0.stat_branch_stalls), 0);
`endif
        mclear();
        exp_ld_stalls = 0;
        exp_br_stalls = 0;
        drive(nop());
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_cycle(alu(6, 5, 1), 1'b0, dummy, "post_rst");

        for (int n = 0; n < 600; n++) begin
            x.v   = ($urandom_range(0, 9) != 0);
            x.rs  = $urandom_range(0, 3);
            x.rt  = $urandom_range(0, 3);
            x.rsu = $urandom_range(0, 3) != 0;
            x.rtu = $urandom_range(0, 1) != 0;
            x.st  = $urandom_range(0, 3) == 0;
            x.rd  = $urandom_range(0, 3);
            x.wr  = $urandom_range(0, 3) != 0;
            x.ld  = $urandom_range(0, 2) == 0;
            x.br  = $urandom_range(0, 3) == 0;
            x.fl  = $urandom_range(0, 15) == 0;
            run_cycle(x, 1'b0, dummy, $sformatf("rnd%0d", n));
        end

`ifdef FWD_STATS_EN
        chk("stat_load_final", int'(if0.stat_load_stalls), exp_ld_stalls);
        chk("stat_branch_final", int'(if0.stat_branch_stalls), exp_br_stalls);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
